// File: rtl/csa_pkg.sv
// Shared types and defaults for the multi-cycle wide-adder scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csa_pkg;

  localparam int SLICE_W_DEF    = 5;
  localparam int NUM_SLICES_DEF = 4;
  localparam int NREQ_DEF       = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_seq_sched_if.sv
// Requester and response bundle for csa_seq_sched.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the result.
// Ports: req_valid/req_ready/req_cin (NREQ), req_a/req_b (NREQ*WIDTH, requester i
//        at [i*WIDTH +: WIDTH]), rsp_valid/rsp_ready, rsp_sum (WIDTH), rsp_cout, rsp_id.
interface csa_seq_sched_if import csa_pkg::*; #(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = SLICE_W_DEF * NUM_SLICES_DEF
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

endinterface

// File: rtl/csa_slice_cin.sv
// SLICE_W-bit carry-select adder with carry-in (needs SLICE_W >= 2).
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i (SLICE_W), cin_i -> sum_o (SLICE_W), cout_o.
module csa_slice_cin #(
  parameter int SLICE_W = 5
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);
  localparam int LO_W = SLICE_W / 2;
  localparam int HI_W = SLICE_W - LO_W;

  logic [LO_W:0] lo;
  logic [HI_W:0] hi0;
  logic [HI_W:0] hi1;

  // Low half ripples; upper half is precomputed for both carries and selected.
  assign lo  = {1'b0, a_i[LO_W-1:0]} + {1'b0, b_i[LO_W-1:0]} + {{LO_W{1'b0}}, cin_i};
  assign hi0 = {1'b0, a_i[SLICE_W-1:LO_W]} + {1'b0, b_i[SLICE_W-1:LO_W]};
  assign hi1 = {1'b0, a_i[SLICE_W-1:LO_W]} + {1'b0, b_i[SLICE_W-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};

  assign {cout_o, sum_o} = lo[LO_W] ? {hi1, lo[LO_W-1:0]} : {hi0, lo[LO_W-1:0]};

endmodule

// File: rtl/csa_seq_sched.sv
// Shares one carry-select slice among NREQ requesters to form a WIDTH-bit a+b+cin.
// Latency: rsp_valid NUM_SLICES+1 cycles after accept; initiation interval NUM_SLICES+2.
// Backpressure: one op in flight; result held in RESP until rsp_ready, no accepts meanwhile.
// Ports: clk, rst_n (async active-low), bus (slave side of csa_seq_sched_if), busy.
module csa_seq_sched import csa_pkg::*; #(
  parameter int SLICE_W    = SLICE_W_DEF,
  parameter int NUM_SLICES = NUM_SLICES_DEF,
  parameter int NREQ       = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csa_seq_sched_if.slave        bus,
  output logic                  busy
);
  localparam int WIDTH = SLICE_W * NUM_SLICES;
  localparam int ID_W  = $clog2(NREQ);
  localparam int IDX_W = idx_width(NUM_SLICES);

  sched_state_t     state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout;

  // Round-robin pick: first asserted valid at or after ptr, wrapping.
  // Walk from lowest priority to highest so the highest-priority hit wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] r;
    int            c;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % NREQ;
      if (v[c]) r = {1'b1, ID_W'(c)};
    end
    return r;
  endfunction

  assign {gnt_found, gnt_id} = rr_pick(bus.req_valid, rr_ptr_q);

  assign sl_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
  assign sl_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W];

  csa_slice_cin #(.SLICE_W(SLICE_W)) u_slice (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (carry_q),
    .sum_o  (sl_sum),
    .cout_o (sl_cout)
  );

  // rst_n gating keeps req_ready at its reset value while reset is held.
  assign bus.req_ready = (state_q == IDLE && gnt_found && rst_n) ? (NREQ'(1) << gnt_id) : '0;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          a_d      = bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
          b_d      = bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
          carry_d  = bus.req_cin[gnt_id];
          id_d     = gnt_id;
          idx_d    = '0;
          rr_ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
          state_d  = CALC;
        end
      end
      CALC: begin
        sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
          // Hold idx on the last pass so it never wraps.
          cout_d  = sl_cout;
          state_d = RESP;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
    end
  end

endmodule
